hazard_scoreboard: RTL and testbench

Parametrised successor to the decode-stage hazard unit. It tracks every in-flight register write across a configurable number of post-decode stages, with a configurable load latency. It generates per-source forwarding selects, load-use stalls and jump/branch fetch flushes for the decode stage. It sits beside the register file in the decode cycle and drives the fetch→decode and decode→execute pipeline registers.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_match.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard scoreboard: table entry layout,
// debug state encoding and the register-file forward select.
package hazard_pkg;

    // Widest register address the table entry can hold; narrower addresses are zero-extended.
    localparam int RD_MAX_W = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_match.sv
// Priority match of one source register against the in-flight write table.
// The youngest matching entry decides both the forward select and availability.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REGISTER_SIZE = 5,
    parameter int FWD_DEPTH     = 3,
    parameter int LOAD_LATENCY  = 1,
    parameter int SEL_W         = $clog2(FWD_DEPTH + 1)
) (
    input  entry_t [FWD_DEPTH:1]     table_q,
    input  logic [REGISTER_SIZE-1:0] rs,
    input  logic                     used,
    output logic [SEL_W-1:0]         sel,
    output logic                     unavailable
);

    logic hit;
    logic hit_load;
    logic live;
    int   hit_k;

    always_comb begin
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_k    = 0;
        // Scan oldest to youngest so the youngest match is the last one kept.
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (table_q[k].valid && (table_q[k].rd == RD_MAX_W'(rs))) begin
                hit      = 1'b1;
                hit_load = table_q[k].is_load;
                hit_k    = k;
            end
        end

        live = used && (rs != '0) && hit;
        // Load data becomes forwardable once it is LOAD_LATENCY stages past execute.
        unavailable = live && hit_load && (hit_k < 1 + LOAD_LATENCY);
        sel = (live && !unavailable) ? SEL_W'(hit_k) : SEL_W'(FWD_RF);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes and produces
// forwarding selects, load-use stalls and redirect flushes for the decode stage.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REGISTER_SIZE = 5,
    parameter int NUM_SRC       = 2,
    parameter int FWD_DEPTH     = 3,
    parameter int LOAD_LATENCY  = 1,
    parameter int SEL_W         = $clog2(FWD_DEPTH + 1),
    parameter int CNT_W         = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 dec_valid,
    input  logic [REGISTER_SIZE-1:0]             dec_rd,
    input  logic                                 dec_rd_write,
    input  logic                                 dec_is_load,
    input  logic [NUM_SRC-1:0][REGISTER_SIZE-1:0] dec_rs,
    input  logic [NUM_SRC-1:0]                   dec_rs_used,
    input  logic                                 redirect,
    output logic                                 f_to_d_enable_ff,
    output logic                                 d_to_e_enable_ff,
    output logic                                 d_to_e_bubble,
    output logic                                 f_to_d_flush,
    output logic [NUM_SRC-1:0][SEL_W-1:0]        pipeline_forward_sel,
    output logic [CNT_W-1:0]                     stall_cycles
);

    entry_t [FWD_DEPTH:1]         table_reg;
    entry_t [FWD_DEPTH:1]         table_next;
    state_t                       state_reg;
    state_t                       state_next;
    logic [CNT_W-1:0]             stall_cycles_reg;
    logic [NUM_SRC-1:0]           src_unavail;
    logic [NUM_SRC-1:0][SEL_W-1:0] match_sel;
    logic                         stall;
    logic                         issue;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            hazard_match #(
                .REGISTER_SIZE(REGISTER_SIZE),
                .FWD_DEPTH    (FWD_DEPTH),
                .LOAD_LATENCY (LOAD_LATENCY),
                .SEL_W        (SEL_W)
            ) u_match (
                .table_q    (table_reg),
                .rs         (dec_rs[gi]),
                .used       (dec_rs_used[gi]),
                .sel        (match_sel[gi]),
                .unavailable(src_unavail[gi])
            );
        end
    endgenerate

    assign stall = dec_valid && (|src_unavail);
    assign issue = dec_valid && !stall && dec_rd_write && (dec_rd != '0);

    always_comb begin
        table_next = '0;
        for (int k = FWD_DEPTH; k >= 2; k--) begin
            table_next[k] = table_reg[k-1];
        end
        // A stalled or non-writing decode slot enters execute as an empty entry.
        if (issue) begin
            table_next[1].valid   = 1'b1;
            table_next[1].rd      = RD_MAX_W'(dec_rd);
            table_next[1].is_load = dec_is_load;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     state_next = stall ? STALL : RUN;
            STALL:   state_next = stall ? STALL : RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            table_reg        <= '0;
            state_reg        <= RUN;
            stall_cycles_reg <= '0;
        end else begin
            table_reg <= table_next;
            state_reg <= state_next;
            if ((state_next == STALL) && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
        end
    end

    assign f_to_d_enable_ff     = !stall;
    assign d_to_e_enable_ff     = 1'b1;
    assign d_to_e_bubble        = stall;
    assign f_to_d_flush         = redirect && dec_valid && !stall;
    assign pipeline_forward_sel = stall ? '0 : match_sel;
    assign stall_cycles         = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, hand-written
// reset-during-stall sequence, then random traffic against an age-list model.
module tb_hazard_scoreboard;

    localparam int FWD_DEPTH = 3;
    localparam int LL        = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             dec_valid;
    logic [4:0]       dec_rd;
    logic             dec_rd_write;
    logic             dec_is_load;
    logic [1:0][4:0]  dec_rs;
    logic [1:0]       dec_rs_used;
    logic             redirect;

    logic             fen, den, bub, flush;
    logic [1:0][1:0]  fsel;
    logic [31:0]      sc;
    logic             fen_s, den_s, bub_s, flush_s;
    logic [1:0][1:0]  fsel_s;
    logic [1:0]       sc_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LATENCY(LL)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rd(dec_rd),
        .dec_rd_write(dec_rd_write), .dec_is_load(dec_is_load), .dec_rs(dec_rs),
        .dec_rs_used(dec_rs_used), .redirect(redirect),
        .f_to_d_enable_ff(fen), .d_to_e_enable_ff(den), .d_to_e_bubble(bub),
        .f_to_d_flush(flush), .pipeline_forward_sel(fsel), .stall_cycles(sc)
    );

    // Narrow counter instance, used to observe saturation.
    hazard_scoreboard #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LATENCY(LL), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rd(dec_rd),
        .dec_rd_write(dec_rd_write), .dec_is_load(dec_is_load), .dec_rs(dec_rs),
        .dec_rs_used(dec_rs_used), .redirect(redirect),
        .f_to_d_enable_ff(fen_s), .d_to_e_enable_ff(den_s), .d_to_e_bubble(bub_s),
        .f_to_d_flush(flush_s), .pipeline_forward_sel(fsel_s), .stall_cycles(sc_s)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic       u0;
        logic       u1;
        logic       redir;
        logic       e_fen;
        logic       e_flush;
        int         e_s0;
        int         e_s1;
        int         e_sc;
    } vec_t;

    typedef struct {
        int rd;
        bit ld;
        int age;
    } inflight_t;

    vec_t      vecs[$];
    inflight_t fl[$];
    int        model_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input int rd, input logic wr, input logic ld,
                                input int rs0, input int rs1, input logic u0, input logic u1,
                                input logic redir, input logic e_fen, input logic e_flush,
                                input int e_s0, input int e_s1, input int e_sc);
        vec_t t;
        t.valid = v; t.rd = 5'(rd); t.wr = wr; t.ld = ld;
        t.rs0 = 5'(rs0); t.rs1 = 5'(rs1); t.u0 = u0; t.u1 = u1; t.redir = redir;
        t.e_fen = e_fen; t.e_flush = e_flush; t.e_s0 = e_s0; t.e_s1 = e_s1; t.e_sc = e_sc;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic u0,
                         input logic u1, input logic redir);
        dec_valid = v; dec_rd = rd; dec_rd_write = wr; dec_is_load = ld;
        dec_rs[0] = rs0; dec_rs[1] = rs1; dec_rs_used = {u1, u0}; redirect = redir;
    endtask

    // Youngest in-flight write to rs decides; loads need LL stages beyond execute.
    function automatic void ref_src(input int rs, input bit used, output int sel, output bit un);
        int best;
        best = -1;
        sel  = 0;
        un   = 1'b0;
        if (!used || rs == 0) return;
        foreach (fl[j]) begin
            if (fl[j].rd == rs && (best < 0 || fl[j].age < fl[best].age)) best = j;
        end
        if (best < 0) return;
        if (fl[best].ld && fl[best].age <= LL) un = 1'b1;
        else sel = fl[best].age;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        fl.delete();
        model_cnt = 0;
    endtask

    initial begin
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        //          v  rd wr ld rs0 rs1 u0 u1 rdr | fen fl s0 s1 sc
        vecs.push_back(mk(1, 5, 1, 0,  0,  0, 0, 0, 0,  1, 0, 0, 0, 0)); // add x5
        vecs.push_back(mk(1, 6, 1, 0,  5,  0, 1, 1, 0,  1, 0, 1, 0, 0)); // add x6,x5,x0
        vecs.push_back(mk(1, 7, 1, 0,  5,  5, 1, 1, 0,  1, 0, 2, 2, 0)); // sub x7,x5,x5
        vecs.push_back(mk(1, 8, 1, 1,  0,  0, 0, 0, 0,  1, 0, 0, 0, 0)); // lw x8
        vecs.push_back(mk(1, 9, 1, 0,  8,  8, 1, 1, 0,  0, 0, 0, 0, 0)); // add x9,x8,x8 stall
        vecs.push_back(mk(1, 9, 1, 0,  8,  8, 1, 1, 0,  1, 0, 2, 2, 1)); // released
        vecs.push_back(mk(1, 3, 1, 0,  0,  0, 0, 0, 0,  1, 0, 0, 0, 1)); // add x3
        vecs.push_back(mk(1, 3, 1, 1,  0,  0, 0, 0, 0,  1, 0, 0, 0, 1)); // lw x3
        vecs.push_back(mk(1, 10, 1, 0, 3,  0, 1, 1, 0,  0, 0, 0, 0, 1)); // use x3: load wins
        vecs.push_back(mk(1, 10, 1, 0, 3,  0, 1, 1, 0,  1, 0, 2, 0, 2));
        vecs.push_back(mk(1, 0, 1, 0,  0,  0, 0, 0, 0,  1, 0, 0, 0, 2)); // add x0
        vecs.push_back(mk(1, 0, 1, 1,  0,  0, 0, 0, 0,  1, 0, 0, 0, 2)); // lw x0
        vecs.push_back(mk(1, 0, 0, 0,  0,  0, 1, 1, 0,  1, 0, 0, 0, 2)); // use x0
        vecs.push_back(mk(1, 12, 1, 1, 0,  0, 0, 0, 0,  1, 0, 0, 0, 2)); // lw x12
        vecs.push_back(mk(1, 13, 1, 0, 12, 0, 1, 1, 1,  0, 0, 0, 0, 2)); // redirect while stalled
        vecs.push_back(mk(1, 13, 1, 0, 12, 0, 1, 1, 1,  1, 1, 2, 0, 3)); // flush on release
        vecs.push_back(mk(0, 0, 0, 0,  13, 12, 1, 1, 1, 1, 0, 1, 3, 3)); // idle slot, oldest fwd

        do_reset();
        @(posedge clk);
        #1;
        chk("reset_fen", 32'(fen), 32'd1);
        chk("reset_bubble", 32'(bub), 32'd0);
        chk("reset_sc", sc, 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].ld, vecs[i].rs0,
                  vecs[i].rs1, vecs[i].u0, vecs[i].u1, vecs[i].redir);
            @(negedge clk);
            chk($sformatf("vec%0d_fen", i), 32'(fen), 32'(vecs[i].e_fen));
            chk($sformatf("vec%0d_den", i), 32'(den), 32'd1);
            chk($sformatf("vec%0d_bubble", i), 32'(bub), 32'(vecs[i].valid && !vecs[i].e_fen));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_sel0", i), 32'(fsel[0]), 32'(vecs[i].e_s0));
            chk($sformatf("vec%0d_sel1", i), 32'(fsel[1]), 32'(vecs[i].e_s1));
            chk($sformatf("vec%0d_sc", i), sc, 32'(vecs[i].e_sc));
            $display("vec %0d: fen=%0d bub=%0d flush=%0d sel=%0d/%0d sc=%0d",
                     i, fen, bub, flush, fsel[0], fsel[1], sc);
            @(posedge clk);
            #1;
        end

        // Reset asserted in the middle of a load-use stall.
        drive(1'b1, 5'd20, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 5'd21, 1'b1, 1'b0, 5'd20, 5'd20, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("midstall_stalled", 32'(fen), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_fen", 32'(fen), 32'd1);
        chk("midrst_bubble", 32'(bub), 32'd0);
        chk("midrst_flush", 32'(flush), 32'd1);
        chk("midrst_sel0", 32'(fsel[0]), 32'd0);
        chk("midrst_sc", sc, 32'd0);
        $display("reset mid-stall: fen=%0d bub=%0d sc=%0d", fen, bub, sc);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("postrst_sc", sc, 32'd0);
        chk("postrst_fen", 32'(fen), 32'd1);

        // Random traffic against the age-list model.
        do_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            int  s0, s1;
            bit  un0, un1, stall_e, issue_e;
            drive(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            ref_src(int'(dec_rs[0]), dec_rs_used[0], s0, un0);
            ref_src(int'(dec_rs[1]), dec_rs_used[1], s1, un1);
            stall_e = dec_valid && (un0 || un1);
            if (stall_e) begin
                s0 = 0;
                s1 = 0;
            end
            @(negedge clk);
            chk($sformatf("rnd%0d_fen", c), 32'(fen), 32'(!stall_e));
            chk($sformatf("rnd%0d_bubble", c), 32'(bub), 32'(stall_e));
            chk($sformatf("rnd%0d_flush", c), 32'(flush), 32'(redirect && dec_valid && !stall_e));
            chk($sformatf("rnd%0d_sel0", c), 32'(fsel[0]), 32'(s0));
            chk($sformatf("rnd%0d_sel1", c), 32'(fsel[1]), 32'(s1));
            chk($sformatf("rnd%0d_sc", c), sc, 32'(model_cnt));
            chk($sformatf("rnd%0d_sat_sc", c), 32'(sc_s), 32'((model_cnt > 3) ? 3 : model_cnt));
            chk($sformatf("rnd%0d_sat_fen", c), 32'(fen_s), 32'(!stall_e));
            $display("rnd %0d: v=%0d stall=%0d sel=%0d/%0d sc=%0d", c, dec_valid, stall_e,
                     fsel[0], fsel[1], sc);
            issue_e = dec_valid && !stall_e && dec_rd_write && (dec_rd != 5'd0);
            @(posedge clk);
            for (int j = fl.size() - 1; j >= 0; j--) begin
                fl[j].age++;
                if (fl[j].age > FWD_DEPTH) fl.delete(j);
            end
            if (issue_e) fl.push_back('{rd: int'(dec_rd), ld: dec_is_load, age: 1});
            if (stall_e) model_cnt++;
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
